// File: rtl/video_in_store.sv
// Capture-side DMA: packs the incoming 8-bit pixel stream into 32-bit words, queues them in a
// word FIFO and writes each frame to memory as Wishbone master bursts, then raises an interrupt.
module video_in_store #(
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned FIFO_AW   = 5
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_data,
    input  logic [31:0] wb_reg_ctr,
    input  logic        pixel_en,
    input  logic        frame_valid,
    input  logic        line_valid,
    input  logic [7:0]  pixel_in,
    output logic        interrupt,
    output logic        overflow,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    output logic [31:0] p_wb_DAT_O,
    input  logic        p_wb_ACK_I
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   DepthC    = (FIFO_AW + 1)'(Depth);
    localparam logic [FIFO_AW:0]   BurstLen  = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [FIFO_AW:0]   BurstLast = (FIFO_AW + 1)'(BURST_LEN - 1);
    localparam logic [FIFO_AW:0]   CntOne    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PtrOne    = FIFO_AW'(1);

    typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

    state_e             state_q, state_d;
    logic               fv_q, armed_q, armed_d;
    logic [1:0]         pack_q, pack_d;
    logic [31:0]        acc_q, acc_d;
    logic               push_q, push_d, end_q, end_d;
    logic [31:0]        push_data_q, push_data_d;
    logic               pending_q, defer_q, overflow_q, irq_q;
    logic [31:0]        addr_q, defer_base_q;
    logic [FIFO_AW:0]   count_q, count_d, old_left_q, beat_q;
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]        mem [Depth];

    logic        fv_rise, fv_fall, arm, take, frame_end, busy_prev;
    logic        fifo_full, fifo_empty, push_ok, pop, old_done, irq_fire, last_beat, cyc;
    logic [31:0] base;
    logic        unused_bits;

    assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

    assign fv_rise    = pixel_en & frame_valid & ~fv_q;
    assign fv_fall    = pixel_en & ~frame_valid & fv_q;
    assign arm        = fv_rise & wb_reg_ctr[0];
    assign take       = pixel_en & frame_valid & line_valid & (armed_q | arm);
    assign frame_end  = fv_fall & armed_q;
    assign base       = {wb_reg_data[31:2], 2'b00};
    // A finished frame is still draining (or its last push is in flight).
    assign busy_prev  = pending_q | end_q;

    assign fifo_full  = (count_q == DepthC);
    assign fifo_empty = (count_q == '0);
    assign push_ok    = push_q & ~fifo_full;
    assign pop        = (state_q == StBurst) & p_wb_ACK_I & ~fifo_empty;
    // old_left counts words of the finished frame still queued, so queued words of a
    // following frame are never written to the previous buffer.
    assign old_done   = pending_q & (old_left_q == '0);
    assign irq_fire   = (state_q == StGap) & old_done;
    assign last_beat  = pop & ((beat_q == BurstLast) | (pending_q & (old_left_q == CntOne)));

    // Pixel packing, big-endian within the word.
    always_comb begin
        armed_d     = armed_q;
        pack_d      = pack_q;
        acc_d       = acc_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        end_d       = 1'b0;
        if (arm) begin
            armed_d = 1'b1;
            pack_d  = 2'd0;
            acc_d   = '0;
        end
        if (take) begin
            unique case (pack_d)
                2'd0: acc_d[31:24] = pixel_in;
                2'd1: acc_d[23:16] = pixel_in;
                2'd2: acc_d[15:8]  = pixel_in;
                2'd3: acc_d[7:0]   = pixel_in;
            endcase
            if (pack_d == 2'd3) begin
                push_d      = 1'b1;
                push_data_d = acc_d;
                acc_d       = '0;
                pack_d      = 2'd0;
            end else begin
                pack_d = pack_d + 2'd1;
            end
        end
        if (frame_end) begin
            armed_d = 1'b0;
            end_d   = 1'b1;
            pack_d  = 2'd0;
            acc_d   = '0;
            if (pack_q != 2'd0) begin
                push_d      = 1'b1;
                push_data_d = acc_q;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CntOne;
        end else if (!push_ok && pop) begin
            count_d = count_q - CntOne;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (old_done) begin
                    state_d = StGap;
                end else if ((count_q >= BurstLen) || (pending_q && (old_left_q != '0))) begin
                    state_d = StBurst;
                end
            end
            StBurst: if (last_beat) state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= StIdle;
            fv_q         <= 1'b0;
            armed_q      <= 1'b0;
            pack_q       <= 2'd0;
            acc_q        <= '0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            end_q        <= 1'b0;
            pending_q    <= 1'b0;
            defer_q      <= 1'b0;
            defer_base_q <= '0;
            overflow_q   <= 1'b0;
            irq_q        <= 1'b0;
            addr_q       <= '0;
            count_q      <= '0;
            old_left_q   <= '0;
            beat_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q     <= state_d;
            if (pixel_en) fv_q <= frame_valid;
            armed_q     <= armed_d;
            pack_q      <= pack_d;
            acc_q       <= acc_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            end_q       <= end_d;
            count_q     <= count_d;
            irq_q       <= irq_fire;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;

            if (end_q) begin
                pending_q  <= 1'b1;
                old_left_q <= count_d;
            end else begin
                if (irq_fire) pending_q <= 1'b0;
                if (pop && pending_q && (old_left_q != '0)) old_left_q <= old_left_q - CntOne;
            end

            if (arm) begin
                overflow_q <= 1'b0;
            end else if (push_q && fifo_full) begin
                overflow_q <= 1'b1;
            end

            // A base programmed while the previous frame drains is applied once it completes.
            if (irq_fire) begin
                defer_q <= 1'b0;
                if (arm) begin
                    addr_q <= base;
                end else if (defer_q) begin
                    addr_q <= defer_base_q;
                end
            end else if (arm) begin
                if (busy_prev) begin
                    defer_q      <= 1'b1;
                    defer_base_q <= base;
                end else begin
                    addr_q <= base;
                end
            end else if (pop) begin
                addr_q <= addr_q + 32'd4;
            end

            if (state_q != StBurst) begin
                beat_q <= '0;
            end else if (pop) begin
                beat_q <= beat_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data_q;
    end

    always_comb begin
        cyc         = (state_q == StBurst);
        p_wb_CYC_O  = cyc;
        p_wb_STB_O  = cyc;
        p_wb_LOCK_O = cyc;
        p_wb_WE_O   = cyc;
        p_wb_SEL_O  = {4{cyc}};
        p_wb_ADR_O  = cyc ? addr_q : 32'd0;
        p_wb_DAT_O  = cyc ? mem[rd_ptr_q] : 32'd0;
        interrupt   = irq_q;
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_video_in_store.sv
// Self-checking bench for video_in_store: directed and randomized frames against a
// frame-level reference model of the words and addresses that must reach memory.
module tb_video_in_store;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] wb_reg_data, wb_reg_ctr;
    logic        pixel_en, frame_valid, line_valid;
    logic [7:0]  pixel_in;
    logic        interrupt, overflow;
    logic        p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O;
    logic [3:0]  p_wb_SEL_O;
    logic [31:0] p_wb_ADR_O, p_wb_DAT_O;
    logic        p_wb_ACK_I = 1'b0;

    video_in_store #(.BURST_LEN(4), .FIFO_AW(5)) dut (
        .clk(clk), .nRST(nRST), .wb_reg_data(wb_reg_data), .wb_reg_ctr(wb_reg_ctr),
        .pixel_en(pixel_en), .frame_valid(frame_valid), .line_valid(line_valid),
        .pixel_in(pixel_in), .interrupt(interrupt), .overflow(overflow),
        .p_wb_STB_O(p_wb_STB_O), .p_wb_CYC_O(p_wb_CYC_O), .p_wb_LOCK_O(p_wb_LOCK_O),
        .p_wb_WE_O(p_wb_WE_O), .p_wb_SEL_O(p_wb_SEL_O), .p_wb_ADR_O(p_wb_ADR_O),
        .p_wb_DAT_O(p_wb_DAT_O), .p_wb_ACK_I(p_wb_ACK_I)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Wishbone slave / bus monitor
    logic        ack_hold = 1'b0;
    int          ack_max = 0;
    bit          ack_rnd = 1'b0;
    logic [31:0] wr_adr[$], wr_dat[$];
    int          irq_cnt = 0, irq_lat = -1, last_ack_neg = 0;
    int          bus_err = 0, unstable = 0, burst_cnt = 0, wait_cnt = 0;
    logic        cyc_prev = 1'b0;
    bit          have_word = 1'b0;
    logic [31:0] cur_adr, cur_dat;

    always @(negedge clk) begin
        if (!nRST) begin
            p_wb_ACK_I = 1'b0;
            have_word  = 1'b0;
            cyc_prev   = 1'b0;
        end else begin
            if (p_wb_CYC_O && !cyc_prev) burst_cnt++;
            cyc_prev = p_wb_CYC_O;
            if (interrupt) begin
                irq_cnt++;
                irq_lat = cyc_cnt - last_ack_neg;
            end
            if (p_wb_CYC_O) begin
                if (!(p_wb_STB_O && p_wb_WE_O && p_wb_LOCK_O && p_wb_SEL_O == 4'hF)) bus_err++;
            end else if (p_wb_STB_O || p_wb_WE_O || p_wb_LOCK_O || p_wb_SEL_O != 4'h0 ||
                         p_wb_ADR_O != 32'h0 || p_wb_DAT_O != 32'h0) begin
                bus_err++;
            end
            if (p_wb_ACK_I) begin
                p_wb_ACK_I = 1'b0;
                have_word  = 1'b0;
            end
            if (ack_hold) begin
                have_word = 1'b0;
            end else if (p_wb_CYC_O && p_wb_STB_O) begin
                if (!have_word) begin
                    have_word = 1'b1;
                    cur_adr   = p_wb_ADR_O;
                    cur_dat   = p_wb_DAT_O;
                    wait_cnt  = ack_rnd ? int'($urandom_range(ack_max, 0)) : ack_max;
                end else if (p_wb_ADR_O != cur_adr || p_wb_DAT_O != cur_dat) begin
                    unstable++;
                end
                if (wait_cnt == 0) begin
                    p_wb_ACK_I = 1'b1;
                    wr_adr.push_back(p_wb_ADR_O);
                    wr_dat.push_back(p_wb_DAT_O);
                    last_ack_neg = cyc_cnt;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Reference model: the frame's pixels packed four per word, first pixel in the top byte,
    // a trailing partial group zero-padded.
    logic [7:0]  px_q[$];
    logic [31:0] exp_w[$];

    task automatic build_expected();
        exp_w.delete();
        for (int i = 0; i < px_q.size(); i += 4) begin
            logic [31:0] w;
            w = 32'h0;
            for (int j = 0; j < 4; j++)
                if (i + j < px_q.size()) w = w | ({24'h0, px_q[i + j]} << (24 - 8 * j));
            exp_w.push_back(w);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic fv, input logic lv, input logic [7:0] px);
        @(negedge clk);
        frame_valid = fv;
        line_valid  = lv;
        pixel_in    = px;
        pixel_en    = 1'b1;
        @(negedge clk);
        pixel_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input int w, input int h, input bit rnd, input logic [7:0] start,
                              input bit en_mid);
        px_q.delete();
        tick(1'b1, 1'b0, 8'h00);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                logic [7:0] p;
                p = rnd ? 8'($urandom) : start + 8'(y * w + x);
                px_q.push_back(p);
                tick(1'b1, 1'b1, p);
                if (en_mid) wb_reg_ctr = 32'h1;
            end
            tick(1'b1, 1'b0, 8'h00);
        end
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic begin_test();
        wr_adr.delete();
        wr_dat.delete();
        irq_cnt   = 0;
        irq_lat   = -1;
        burst_cnt = 0;
        unstable  = 0;
    endtask

    task automatic wait_irq(input int target, input string tag);
        int n;
        n = 0;
        while (irq_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk(tag, irq_cnt, target);
    endtask

    task automatic compare_writes(input logic [31:0] base, input string tag);
        chk({tag, "_nwords"}, wr_adr.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_adr.size(); i++) begin
            chk($sformatf("%s_adr%0d", tag, i), wr_adr[i], base + 32'(4 * i));
            chk($sformatf("%s_dat%0d", tag, i), wr_dat[i], exp_w[i]);
        end
    endtask

    initial begin
        logic [31:0] b;
        int n;
        wb_reg_data = 32'h0;
        wb_reg_ctr  = 32'h0;
        pixel_en    = 1'b0;
        frame_valid = 1'b0;
        line_valid  = 1'b0;
        pixel_in    = 8'h0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {26'h0, interrupt, overflow, p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O,
                        p_wb_WE_O}, 32'h0);
        chk("rst_sel", {28'h0, p_wb_SEL_O}, 32'h0);
        chk("rst_adr", p_wb_ADR_O, 32'h0);
        chk("rst_dat", p_wb_DAT_O, 32'h0);
        nRST = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 8x4 frame, pixels 0..31
        begin_test();
        wb_reg_data = 32'h0001_0000;
        wb_reg_ctr  = 32'h1;
        send_frame(8, 4, 1'b0, 8'h00, 1'b0);
        build_expected();
        wait_irq(1, "basic_irq");
        compare_writes(32'h0001_0000, "basic");
        chk("basic_w0", wr_dat[0], 32'h0001_0203);
        chk("basic_wlast", wr_dat[wr_dat.size() - 1], 32'h1C1D_1E1F);
        chk("basic_alast", wr_adr[wr_adr.size() - 1], 32'h0001_001C);
        chk("basic_bursts", burst_cnt, 2);

        // Partial last word; base low bits must be ignored
        begin_test();
        wb_reg_data = 32'h2000_0103;
        send_frame(6, 1, 1'b0, 8'hAA, 1'b0);
        build_expected();
        wait_irq(1, "part_irq");
        compare_writes(32'h2000_0100, "part");
        chk("part_w0", wr_dat[0], 32'hAAAB_ACAD);
        chk("part_w1", wr_dat[1], 32'hAEAF_0000);
        chk("part_irq_lat", irq_lat, 2);

        // Wait states
        begin_test();
        ack_max     = 3;
        wb_reg_data = 32'h0000_4000;
        send_frame(8, 3, 1'b1, 8'h00, 1'b0);
        build_expected();
        wait_irq(1, "wait_irq");
        compare_writes(32'h0000_4000, "wait");
        chk("wait_stable", unstable, 0);

        // Overflow with ACK withheld for the whole 64x4 frame
        begin_test();
        ack_max     = 0;
        ack_hold    = 1'b1;
        wb_reg_data = 32'h0008_0000;
        send_frame(64, 4, 1'b1, 8'h00, 1'b0);
        build_expected();
        while (exp_w.size() > 32) void'(exp_w.pop_back());
        chk("ovf_flag", {31'h0, overflow}, 32'h1);
        chk("ovf_no_ack", wr_adr.size(), 0);
        ack_hold = 1'b0;
        wait_irq(1, "ovf_irq");
        compare_writes(32'h0008_0000, "ovf");
        chk("ovf_alast", wr_adr[wr_adr.size() - 1], 32'h0008_007C);

        // Enable low at frame start, raised mid-frame: frame ignored
        begin_test();
        wb_reg_ctr  = 32'h0;
        wb_reg_data = 32'h0009_0000;
        send_frame(8, 2, 1'b1, 8'h00, 1'b1);
        repeat (50) @(negedge clk);
        chk("gate_writes", wr_adr.size(), 0);
        chk("gate_irq", irq_cnt, 0);
        chk("gate_bursts", burst_cnt, 0);
        chk("gate_ovf_kept", {31'h0, overflow}, 32'h1);
        begin_test();
        ack_rnd     = 1'b1;
        ack_max     = 2;
        wb_reg_data = 32'h0003_0000;
        send_frame(5, 3, 1'b1, 8'h00, 1'b0);
        build_expected();
        wait_irq(1, "gate_next_irq");
        compare_writes(32'h0003_0000, "gate_next");
        chk("gate_next_ovf", {31'h0, overflow}, 32'h0);

        // Randomized frames, sizes, bases and ACK latencies
        ack_max = 3;
        for (int k = 0; k < 3; k++) begin
            begin_test();
            wb_reg_data = $urandom;
            b = wb_reg_data & 32'hFFFF_FFFC;
            send_frame(int'($urandom_range(10, 1)), int'($urandom_range(4, 1)), 1'b1, 8'h00,
                       1'b0);
            build_expected();
            wait_irq(1, $sformatf("rnd%0d_irq", k));
            compare_writes(b, $sformatf("rnd%0d", k));
        end

        // Reset in the middle of a stalled burst
        begin_test();
        ack_rnd     = 1'b0;
        ack_max     = 0;
        ack_hold    = 1'b1;
        wb_reg_data = 32'h0005_0000;
        send_frame(8, 2, 1'b1, 8'h00, 1'b0);
        n = 0;
        while (!p_wb_CYC_O && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rstm_cyc_seen", {31'h0, p_wb_CYC_O}, 32'h1);
        @(negedge clk);
        #2 nRST = 1'b0;
        #1;
        chk("rstm_cyc", {31'h0, p_wb_CYC_O}, 32'h0);
        chk("rstm_stb", {31'h0, p_wb_STB_O}, 32'h0);
        chk("rstm_irq", {31'h0, interrupt}, 32'h0);
        repeat (2) @(negedge clk);
        ack_hold = 1'b0;
        begin_test();
        nRST = 1'b1;
        repeat (40) @(negedge clk);
        chk("rstm_no_writes", wr_adr.size(), 0);
        chk("rstm_no_irq", irq_cnt, 0);
        chk("rstm_ovf", {31'h0, overflow}, 32'h0);
        wb_reg_data = 32'h0006_0000;
        send_frame(7, 2, 1'b1, 8'h00, 1'b0);
        build_expected();
        wait_irq(1, "rstm_new_irq");
        compare_writes(32'h0006_0000, "rstm_new");

        chk("bus_protocol", bus_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_in_store.md
# video_in_store

Capture-side DMA stage that mirrors the display path. It samples the incoming pixel stream (line_valid / frame_valid / 8-bit pixel) and packs four pixels per 32-bit word into an internal word FIFO. It then writes each frame to RAM as Wishbone master bursts, starting at the buffer address programmed through the Wishbone slave registers. It raises an interrupt once the last word of a frame is acknowledged, so software can hand the buffer to the display stage.

## Interface
- BURST_LEN, 16: words per Wishbone burst; power of 2, at most 2^FIFO_AW.
- FIFO_AW, 5: word-FIFO address width (depth 32 words).
- Clock/reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, 100 MHz; all logic on rising edge.
- nRST  in  1  asynchronous active-low reset.
- wb_reg_data  in  32  frame buffer base address, byte address, bits [1:0] ignored.
- wb_reg_ctr  in  32  bit0 = capture enable; other bits ignored.
- pixel_en  in  1  pixel qualifier, one-cycle strobe per pixel clock, synchronous to clk.
- frame_valid  in  1  frame active.
- line_valid  in  1  line active.
- pixel_in  in  8  pixel data.
- interrupt  out  1  one-cycle pulse, end of stored frame.
- overflow  out  1  sticky; a word was dropped on a full FIFO this frame.
- p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O  out  1  Wishbone master strobe, cycle, lock.
- p_wb_WE_O  out  1  always 1 while CYC is high.
- p_wb_SEL_O  out  4  always 4'hF while CYC is high.
- p_wb_ADR_O  out  32  word-aligned write address.
- p_wb_DAT_O  out  32  write data.
- p_wb_ACK_I  in  1  slave acknowledge.

## Operation
- **Reset:** all outputs are 0. FIFO is empty. Pack counter is 0. FSM is IDLE. Capture is unarmed.
- **Arming:** on a sampled rising edge of frame_valid (qualified by pixel_en) with wb_reg_ctr[0]=1:
  - latch addr_ptr <= {wb_reg_data[31:2], 2'b00};
  - clear overflow;
  - arm capture.
- **Enable is checked only at frame start.** A frame starting with enable=0 is ignored entirely. Dropping enable mid-frame does not abort the frame.
- **Pixel sampling:** a pixel is taken when pixel_en & frame_valid & line_valid & armed.
- **Packing is big-endian.** The first pixel of a group goes to [31:24], the fourth to [7:0]. The pack counter is 2 bits and wraps 3->0; on the wrap the word is pushed.
- **Frame end:** the falling edge of frame_valid (sampled with pixel_en) marks frame end.
  - If the pack counter is nonzero, the partial word is zero-padded in its low bytes and pushed.
  - Then frame_done_pending is set and armed is cleared.
- **Overflow:** a push attempted while the FIFO is full drops that word and sets overflow. The address pointer does not advance for dropped words.
- **Write FSM states:** IDLE, BURST, GAP.
  - IDLE -> BURST when FIFO count >= BURST_LEN, or when (frame_done_pending and FIFO not empty).
  - BURST: CYC=STB=LOCK=1; ADR=addr_ptr; DAT=FIFO head.
  - On each ACK in BURST: pop the FIFO, addr_ptr += 4 (32-bit wrap), increment the word count.
  - BURST -> GAP after BURST_LEN ACKs, or on an ACK that empties the FIFO while frame_done_pending.
  - GAP -> IDLE after one cycle.
- **Interrupt:** in GAP, if frame_done_pending and the FIFO is empty, pulse interrupt for one cycle and clear frame_done_pending.
- **Back-to-back frames:** a new frame arming while frame_done_pending is still set re-latches addr_ptr only after the pending interrupt has fired. Its incoming words queue in the FIFO meanwhile.

## Timing
- A word is written into the FIFO on the cycle after its 4th pixel is sampled.
- CYC/STB rise on the cycle after the IDLE start condition is true.
- ADR/DAT are stable while STB=1 until ACK. The next word appears the cycle after ACK.
- Single-cycle ACK sustains 1 word/cycle.
- CYC/STB fall the cycle after the last ACK of a burst. There is at least one idle cycle (GAP) between bursts.
- interrupt pulses exactly 2 cycles after the final ACK of a frame.
- Simultaneous push and pop in one cycle: count unchanged; both take effect.
- nRST asserted mid-burst drops CYC/STB immediately (asynchronous). FIFO contents are lost and no interrupt is issued.

## Test plan
- **Basic frame:** enable=1, base 0x0001_0000, 8x4 frame with pixels 0..31 -> 2 bursts of 4 with BURST_LEN=4; word0=0x00010203 @0x10000; last word 0x1C1D1E1F @0x1001C; one interrupt pulse.
- **Partial word:** 6-pixel frame, pixels AA..AF -> words 0xAAABACAD, then 0xAEAF0000; interrupt after the 2nd ACK.
- **Wait states:** ACK delayed 3 cycles per word -> ADR/DAT held stable; no word lost or duplicated; addresses contiguous.
- **Overflow:** ACK held low for a whole 64x4 frame -> overflow=1; FIFO holds 32 words; after ACK is released, 32 words are written to base..base+0x7C, then interrupt.
- **Enable gating:** enable=0 at frame start, set mid-frame -> no Wishbone activity, no interrupt. The next frame is captured normally.
- **Reset mid-burst:** nRST low during BURST -> CYC/STB/interrupt=0 in the same cycle. After release, a fresh frame is stored from the newly latched base.
